uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
Reader/consumer end of the 8-bit transmit FIFO. It watches the FIFO status, pops one byte whenever the FIFO is not empty, and serialises it onto the UART line as 8N1 (optionally 8N2), LSB first. It sits between the TX FIFO output and the Tx pin.

Parameters:
Clks_Per_Bit, 16, Clk cycles per UART bit; legal range 2..65535; counter width is clog2(Clks_Per_Bit).
Stop_Bits, 1, number of stop bits; legal values are 1 or 2.

Ports:
Clk  input  1  system clock; all logic is on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Enable  input  1  when 1, new frames may start; when 0, the block finishes the current frame and then idles.
Fifo_Status  input  4  FIFO flags; bit0 = Empty, bit1 = Full, bit2 = AFull, bit3 = AEmpty. Only bit0 is used.
Fifo_Data  input  8  FIFO read data; valid one Clk cycle after Fifo_Read is asserted.
Fifo_Read  output  1  one-cycle pop strobe to the FIFO.
Tx  output  1  serial line; idle level is 1.
Busy  output  1  1 in every state except IDLE.
Tx_Done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high.
  - While Reset=1: state=IDLE, Tx=1, Fifo_Read=0, Busy=0, Tx_Done=0, shift register=0, bit counter=0, baud counter=0.
  - Reset asserted mid-frame aborts the frame immediately: Tx returns to 1 with no partial stop bit, and the FIFO byte is lost.
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - Tx=1.
  - If Enable=1 and Fifo_Status[0]=0, go to FETCH.
- FETCH (1 cycle):
  - Fifo_Read=1.
  - Next state is LOAD unconditionally.
- LOAD (1 cycle):
  - Shift register <= Fifo_Data.
  - Baud counter <= 0.
  - Next state is START.
  - Tx is still 1.
- START:
  - Tx=0 for exactly Clks_Per_Bit cycles.
  - Then go to DATA with bit counter=0.
- DATA:
  - Tx = shift register bit0.
  - Each bit lasts Clks_Per_Bit cycles.
  - At the end of each bit: shift right by one and increment the bit counter.
  - After bit 7, go to STOP.
- STOP:
  - Tx=1 for Stop_Bits*Clks_Per_Bit cycles.
  - On the last cycle: Tx_Done=1.
  - If Enable=1 and Fifo_Status[0]=0, next state is FETCH; otherwise IDLE.
- Baud counter:
  - Counts 0..Clks_Per_Bit-1, is compared against Clks_Per_Bit-1, and wraps to 0 at each bit boundary.
  - No free-running divider, so every frame is phase-aligned to LOAD.
- Timing:
  - Frame latency from FIFO non-empty seen in IDLE to the falling start edge on Tx is 3 Clk cycles (FETCH, LOAD, then the first START cycle).
  - Back-to-back frames have exactly 2 extra idle-high cycles (FETCH+LOAD) between the stop bit end and the next start bit.
- Fifo_Read is asserted only in FETCH. It is never asserted when Fifo_Status[0]=1 was sampled, so the FIFO is never underflowed.
- Enable deassertion:
  - During START, DATA or STOP it has no effect on the current frame.
  - Deassertion during FETCH or LOAD still completes that frame, because the byte has already been popped.
- Fifo_Status bits 1..3 are ignored.
- Tx is driven from a register, so it is glitch-free.

Test Plan:
- Clks_Per_Bit=4, Stop_Bits=1; Reset pulse; FIFO holds 0x55:
  - Fifo_Read is high exactly 1 cycle.
  - 3 cycles after non-empty is seen, Tx emits 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles (40 cycles total).
  - Tx_Done pulses on cycle 40; Busy is high for 42 cycles.
- FIFO holds 0xA3 then 0x0F:
  - Two frames are sent with data bits 1,1,0,0,0,1,0,1 and 1,1,1,1,0,0,0,0.
  - Exactly 2 idle-high cycles separate them.
  - Fifo_Read pulses twice; Tx_Done pulses twice.
- Empty FIFO (Fifo_Status=4'b1001) with Enable=1 for 100 cycles:
  - Fifo_Read stays 0, Tx stays 1, Busy stays 0.
- Enable dropped during DATA bit 3 with a second byte pending:
  - The current frame completes with a correct stop bit.
  - The block returns to IDLE with no second Fifo_Read.
  - Re-asserting Enable starts the second frame 3 cycles later.
- Reset asserted asynchronously (between Clk edges) during DATA bit 5:
  - Tx=1, Busy=0 and Fifo_Read=0 take effect before the next Clk edge.
  - After release with the FIFO empty, the block stays in IDLE.
- Stop_Bits=2, Clks_Per_Bit=3, byte 0xFF:
  - Tx is low 3 cycles (start), then high 24 cycles of data plus 6 cycles of stop.
  - Tx_Done pulses on cycle 33 of the frame.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// FIFO read-side bundle between the TX FIFO and the UART serializer.
// master: the serializer (consumer) that issues pops.
// slave:  the FIFO that supplies the status flags and the read data.
interface uart_tx_serializer_if;
    logic [3:0] Fifo_Status;  // bit0 Empty, bit1 Full, bit2 AFull, bit3 AEmpty
    logic [7:0] Fifo_Data;    // valid one cycle after Fifo_Read
    logic       Fifo_Read;    // one-cycle pop strobe

    modport master (input Fifo_Status, input Fifo_Data, output Fifo_Read);
    modport slave  (output Fifo_Status, output Fifo_Data, input Fifo_Read);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out
// LSB first as 8N1 or 8N2. The baud counter restarts in LOAD, so every frame
// is phase-aligned to the pop rather than to a free-running divider.
module uart_tx_serializer #(
    parameter int Clks_Per_Bit = 16,  // 2..65535
    parameter int Stop_Bits    = 1    // 1 or 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Enable,
    uart_tx_serializer_if.master    fifo,
    output logic                    Tx,
    output logic                    Busy,
    output logic                    Tx_Done
);
    localparam int              CW        = (Clks_Per_Bit > 1) ? $clog2(Clks_Per_Bit) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(Clks_Per_Bit - 1);
    localparam logic [2:0]      STOP_LAST = 3'(Stop_Bits - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_q, bit_d;     // data bit index in DATA, stop bit index in STOP
    logic [CW-1:0]   baud_q, baud_d;
    logic            tx_q, tx_d;
    logic            baud_last;
    logic            frame_go;
    logic            unused_status;

    assign baud_last     = (baud_q == BAUD_LAST);
    assign frame_go      = Enable && !fifo.Fifo_Status[0];
    assign unused_status = ^fifo.Fifo_Status[3:1];

    // State register; reset aborts any frame in flight and drops the line high
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state, datapath updates and the registered line level for the next cycle
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        Tx_Done = 1'b0;
        case (state_q)
            IDLE:  if (frame_go) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = fifo.Fifo_Data;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                baud_d = baud_q + CW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + CW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                baud_d = baud_q + CW'(1);
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        Tx_Done = 1'b1;
                        bit_d   = '0;
                        state_d = frame_go ? FETCH : IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so Tx comes straight off a flop
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign Tx             = tx_q;
    assign Busy           = (state_q != IDLE);
    assign fifo.Fifo_Read = (state_q == FETCH);
endmodule
